// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for req/rsp bus responders (RAM now, ROM and peripheral
// responders later).
//   BUS_DATA_W        : bus data width
//   BUS_SEL_W         : number of byte-lane enables
//   RSP_DEPTH_DEFAULT : default response queue depth / outstanding limit
//   rsp_entry_t       : one queued response
//   slot_state_t      : occupancy state of a single response queue slot
// ---------------------------------------------------------------------------
package bus_pkg;

   localparam int BUS_DATA_W        = 32;
   localparam int BUS_SEL_W         = 4;
   localparam int RSP_DEPTH_DEFAULT = 2;

   typedef struct packed {
      logic [BUS_DATA_W-1:0] data;
   } rsp_entry_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/rsp_fifo.sv
// ---------------------------------------------------------------------------
// rsp_fifo
// Small synchronous response FIFO. Each slot carries its own EMPTY/FULL state
// machine; the slot at the read pointer is the head of the queue.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data into the slot at the write pointer
//   push_data  : response word to enqueue
//   pop        : retire the head slot
//   head       : data of the head slot (meaningful when !empty)
//   full       : every slot occupied
//   empty      : no slot occupied
// ---------------------------------------------------------------------------
module rsp_fifo
   import bus_pkg::*;
#(
   parameter int DEPTH = RSP_DEPTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [BUS_DATA_W-1:0] push_data,
   input  logic                  pop,
   output logic [BUS_DATA_W-1:0] head,
   output logic                  full,
   output logic                  empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rsp_entry_t       slot_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [DEPTH-1:0] slot_full;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Per-slot occupancy FSM. A push and a pop never target the same slot:
   // that would need the queue to be both full and empty at once.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         slot_state_t state_reg;
         slot_state_t state_next;

         always_comb begin
            state_next = state_reg;
            case (state_reg)
               SLOT_EMPTY: if (push && (wr_ptr_reg == PW'(gi))) state_next = SLOT_FULL;
               SLOT_FULL:  if (pop && (rd_ptr_reg == PW'(gi)))  state_next = SLOT_EMPTY;
            endcase
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               state_reg <= SLOT_EMPTY;
            end else begin
               state_reg <= state_next;
            end
         end

         assign slot_full[gi] = (state_reg == SLOT_FULL);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
   end

   always_ff @(posedge clk) begin
      if (push) slot_reg[wr_ptr_reg].data <= push_data;
   end

   assign head  = slot_reg[rd_ptr_reg].data;
   assign full  = &slot_full;
   assign empty = ~|slot_full;

   a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/ram_responder.sv
// ---------------------------------------------------------------------------
// ram_responder
// Word-addressed on-chip RAM acting as the responder end of a req/rsp bus.
// One request accepted per cycle; the response (read word, or 0 for a write)
// is presented the cycle after acceptance and is queued under back-pressure.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   addr_i       : byte address, word index = addr_i[log2(DEPTH)+1:2]
//   data_i       : write data
//   sel_i        : byte-lane write enables
//   we_i         : 1 = write, 0 = read
//   req_valid_i  : request valid
//   req_ready_o  : request can be accepted (registered state only)
//   data_o       : response data
//   rsp_valid_o  : response valid
//   rsp_ready_i  : initiator takes the response
// ---------------------------------------------------------------------------
module ram_responder
   import bus_pkg::*;
#(
   parameter int    DEPTH     = 4096,
   parameter string INIT_FILE = "",
   parameter int    RSP_DEPTH = RSP_DEPTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           addr_i,
   input  logic [BUS_DATA_W-1:0] data_i,
   input  logic [BUS_SEL_W-1:0]  sel_i,
   input  logic                  we_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   output logic [BUS_DATA_W-1:0] data_o,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(RSP_DEPTH + 1);

   logic [BUS_DATA_W-1:0] mem [DEPTH];
   logic [BUS_DATA_W-1:0] rd_data_reg;
   logic [CW-1:0]         cnt_reg;
   logic [CW-1:0]         cnt_next;
   logic                  rst_q_reg;
   logic                  pend_reg;
   logic                  pend_write_reg;

   logic [AW-1:0]         word_idx;
   logic                  req_ready;
   logic                  rsp_valid;
   logic                  accept;
   logic                  rsp_pop;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [BUS_DATA_W-1:0] pend_data;
   logic [BUS_DATA_W-1:0] fifo_head;
   logic [BUS_DATA_W-1:0] head_data;
   logic                  unused_ok;

   // Upper address bits alias the RAM; byte offset is ignored.
   assign word_idx  = addr_i[AW+1:2];
   assign unused_ok = ^{addr_i[31:AW+2], addr_i[1:0], fifo_full};

   // ---------------------------------------------------------------------
   // Handshakes. Ready is held low during reset and for one cycle after it.
   // ---------------------------------------------------------------------
   assign req_ready = !rst && !rst_q_reg && (cnt_reg < CW'(RSP_DEPTH));
   assign accept    = req_valid_i && req_ready;
   assign rsp_pop   = rsp_valid && rsp_ready_i;

   // ---------------------------------------------------------------------
   // RAM: byte-lane writes and a registered read port.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (accept && we_i) begin
         for (int b = 0; b < BUS_SEL_W; b++) begin
            if (sel_i[b]) mem[word_idx][8*b +: 8] <= data_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !we_i) rd_data_reg <= mem[word_idx];
   end

   // ---------------------------------------------------------------------
   // The RAM output register acts as the tail stage of the response queue:
   // a response lives there for exactly one cycle (pend_reg). If it is not
   // taken directly in that cycle it moves into the FIFO, so the RAM output
   // register is free for the next read. Queue order is therefore FIFO
   // entries first, then the pending stage.
   // ---------------------------------------------------------------------
   assign pend_data = pend_write_reg ? '0 : rd_data_reg;
   assign fifo_push = pend_reg && !(rsp_pop && fifo_empty);
   assign fifo_pop  = rsp_pop && !fifo_empty;
   assign head_data = fifo_empty ? pend_data : fifo_head;

   rsp_fifo #(
      .DEPTH(RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (pend_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      cnt_next = cnt_reg;
      if (accept && !rsp_pop) begin
         cnt_next = cnt_reg + CW'(1);
      end else if (!accept && rsp_pop) begin
         cnt_next = cnt_reg - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      rst_q_reg <= rst;
      if (rst) begin
         cnt_reg        <= '0;
         pend_reg       <= 1'b0;
         pend_write_reg <= 1'b0;
      end else begin
         cnt_reg        <= cnt_next;
         pend_reg       <= accept;
         pend_write_reg <= we_i;
      end
   end

   assign rsp_valid   = !rst && (!fifo_empty || pend_reg);
   assign rsp_valid_o = rsp_valid;
   assign data_o      = rsp_valid ? head_data : '0;
   assign req_ready_o = req_ready;

   a_cnt_bound:    assert property (@(posedge clk) disable iff (rst) cnt_reg <= CW'(RSP_DEPTH));
   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
                      (rsp_valid && !rsp_ready_i) |=> (rsp_valid && $stable(data_o)));

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

   localparam int RSP_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  sel;
   logic        we;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] rdata;
   logic        rsp_valid;
   logic        rsp_ready;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural reference: flat word memory plus a queue of outstanding
   // responses in acceptance order.
   logic [31:0] mmem [4096];
   logic [31:0] mq [$];
   bit          rst_last = 1'b1;

   always #5 clk = ~clk;

   ram_responder dut (
      .clk         (clk),
      .rst         (rst),
      .addr_i      (addr),
      .data_i      (wdata),
      .sel_i       (sel),
      .we_i        (we),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .data_o      (rdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   // Model update on every rising edge.
   initial begin
      forever begin
         bit exp_rdy;
         int idx;
         @(posedge clk);
         if (rst) begin
            mq.delete();
            rst_last = 1'b1;
         end else begin
            exp_rdy = !rst_last && (mq.size() < RSP_DEPTH);
            if (rsp_ready && mq.size() > 0) void'(mq.pop_front());
            if (req_valid && exp_rdy) begin
               idx = int'(addr[13:2]);
               if (we) begin
                  for (int b = 0; b < 4; b++)
                     if (sel[b]) mmem[idx][8*b +: 8] = wdata[8*b +: 8];
                  mq.push_back(32'h0);
               end else begin
                  mq.push_back(mmem[idx]);
               end
            end
            rst_last = 1'b0;
         end
      end
   end

   // Compare DUT outputs against the model on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            check("rst_data", rdata, 32'd0);
            check("rst_req_ready", {31'b0, req_ready}, 32'd0);
         end else begin
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, (mq.size() > 0)});
            check("req_ready", {31'b0, req_ready},
                  {31'b0, (!rst_last && mq.size() < RSP_DEPTH)});
            if (mq.size() > 0) check("rsp_data", rdata, mq[0]);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   // Present a request and hold it until the DUT accepts it; returns 1 time
   // unit after the accepting edge with req_valid dropped.
   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int waited = 0;
      req_valid = 1'b1; we = w; addr = a; wdata = d; sel = s;
      while (!req_ready) begin
         @(posedge clk); #1;
         waited++;
         if (waited >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got no ready in %0d cycles, want ready", waited);
            break;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); check("ready_first_cycle_after_rst", {31'b0, req_ready}, 32'd0);
      @(negedge clk); check("ready_second_cycle_after_rst", {31'b0, req_ready}, 32'd1);

      // Write then read back, latency 1.
      send(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      check("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("wr_rsp_data", rdata, 32'h0);
      send(1'b0, 32'h100, 32'h0, 4'h0);
      @(negedge clk);
      check("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("rd_rsp_data", rdata, 32'hDEADBEEF);
      $display("txn: wr/rd 0x100 -> %h", rdata);

      // Partial byte-lane write.
      send(1'b1, 32'h20, 32'h11223344, 4'hF);
      send(1'b1, 32'h20, 32'h000000AA, 4'b0001);
      send(1'b0, 32'h20, 32'h0, 4'h0);
      @(negedge clk);
      check("byte_lane_merge", rdata, 32'h112233AA);
      $display("txn: byte-lane rd 0x20 -> %h", rdata);

      // Back-to-back reads.
      for (int i = 0; i < 4; i++) send(1'b1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
      for (int i = 0; i < 4; i++) begin
         send(1'b0, 32'(4 * i), 32'h0, 4'h0);
         @(negedge clk);
         check("b2b_ready", {31'b0, req_ready}, 32'd1);
         check("b2b_data", rdata, 32'hC0DE0000 + 32'(i));
         $display("txn: b2b rd 0x%0h -> %h", 4 * i, rdata);
      end
      @(posedge clk); #1;

      // Back-pressure: two outstanding, third blocked.
      rsp_ready = 1'b0;
      send(1'b0, 32'h100, 32'h0, 4'h0);
      send(1'b0, 32'h20, 32'h0, 4'h0);
      req_valid = 1'b1; we = 1'b0; addr = 32'h0;
      @(negedge clk);
      check("bp_third_blocked", {31'b0, req_ready}, 32'd0);
      check("bp_head", rdata, 32'hDEADBEEF);
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_ready_returns", {31'b0, req_ready}, 32'd1);
      check("bp_second", rdata, 32'h112233AA);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      check("bp_full_again", {31'b0, req_ready}, 32'd0);
      check("bp_stall_hold", rdata, 32'h112233AA);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_third_data", rdata, 32'hC0DE0000);
      $display("txn: back-pressure third rd -> %h", rdata);
      @(posedge clk); #1;

      // Aliasing.
      send(1'b0, 32'h4000, 32'h0, 4'h0);
      @(negedge clk);
      check("alias_0x4000", rdata, 32'hC0DE0000);
      $display("txn: alias rd 0x4000 -> %h", rdata);
      @(posedge clk); #1;

      // Reset with responses outstanding.
      rsp_ready = 1'b0;
      send(1'b0, 32'h100, 32'h0, 4'h0);
      send(1'b0, 32'h20, 32'h0, 4'h0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_valid", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_ready_low", {31'b0, req_ready}, 32'd0);
      check("midrst_valid_after", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      check("midrst_ready_back", {31'b0, req_ready}, 32'd1);
      rsp_ready = 1'b1;
      send(1'b0, 32'h100, 32'h0, 4'h0);
      @(negedge clk);
      check("midrst_ram_kept", rdata, 32'hDEADBEEF);
      $display("txn: post-reset rd 0x100 -> %h", rdata);

      // Initialise a small window, then randomized traffic over it.
      for (int i = 0; i < 16; i++) send(1'b1, 32'(4 * i), $urandom, 4'hF);
      for (int c = 0; c < 3000; c++) begin
         int idx;
         idx       = $urandom_range(0, 15);
         rst       = ($urandom_range(0, 199) == 0);
         req_valid = ($urandom_range(0, 3) != 0);
         we        = ($urandom_range(0, 2) == 0);
         addr      = ($urandom & 32'hFFFF_C003) | 32'(idx << 2);
         wdata     = $urandom;
         sel       = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
         if (req_valid && !rst)
            $display("txn: cycle %0d %s idx=%0d rsp_ready=%0d", c, we ? "wr" : "rd", idx, rsp_ready);
      end
      rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
